// File: rtl/apb_gpio_ext_pkg.sv
// Shared constants for the APB GPIO controller: address field positions,
// register word indices within a bank and interrupt type encoding.
package apb_gpio_ext_pkg;

  localparam int BANK_SIZE = 32;
  localparam int BANK_LSB  = 6;
  localparam int BANK_W    = 2;
  localparam int REG_LSB   = 2;
  localparam int REG_W     = 4;

  // Word index within a bank (byte offset >> 2)
  localparam logic [REG_W-1:0] REG_DIR       = 4'h0;
  localparam logic [REG_W-1:0] REG_IN        = 4'h1;
  localparam logic [REG_W-1:0] REG_OUT       = 4'h2;
  localparam logic [REG_W-1:0] REG_OUT_SET   = 4'h3;
  localparam logic [REG_W-1:0] REG_OUT_CLR   = 4'h4;
  localparam logic [REG_W-1:0] REG_OUT_TGL   = 4'h5;
  localparam logic [REG_W-1:0] REG_INTEN     = 4'h6;
  localparam logic [REG_W-1:0] REG_INTTYPE0  = 4'h7;
  localparam logic [REG_W-1:0] REG_INTTYPE1  = 4'h8;
  localparam logic [REG_W-1:0] REG_INTSTATUS = 4'h9;
  localparam logic [REG_W-1:0] REG_FILT_EN   = 4'hA;
  localparam logic [REG_W-1:0] REG_FILT_CFG  = 4'hB;
  localparam logic [REG_W-1:0] REG_PWREVT    = 4'hC;

  // {INTTYPE1, INTTYPE0}
  typedef enum logic [1:0] {
    INT_LEVEL_HIGH = 2'b00,
    INT_LEVEL_LOW  = 2'b01,
    INT_RISE       = 2'b10,
    INT_FALL       = 2'b11
  } int_type_e;

  function automatic logic int_match(input logic [1:0] ty, input logic cur, input logic prev);
    logic m;
    m = 1'b0;
    case (int_type_e'(ty))
      INT_LEVEL_HIGH: m = cur;
      INT_LEVEL_LOW:  m = ~cur;
      INT_RISE:       m = cur & ~prev;
      INT_FALL:       m = ~cur & prev;
      default:        m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/apb_gpio_ext_in_filter.sv
// Per-pin input path: two-flop synchroniser, optional debounce counter,
// filtered value and its one-cycle-delayed copy for edge detection.
module gpio_in_filter
  import apb_gpio_ext_pkg::*;
#(
  parameter int FILT_W = 8
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              pad_i,
  input  logic              filt_en_i,
  input  logic [FILT_W-1:0] thresh_i,
  output logic              in_o,
  output logic              in_q_o
);

  logic              sync0_q, sync1_q;
  logic              in_r_q, in_r_d;
  logic              in_dly_q;
  logic [FILT_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a threshold lowered below a running count still
  // lets the next mismatch cycle through
  always_comb begin
    in_r_d = in_r_q;
    cnt_d  = cnt_q;
    if (!filt_en_i) begin
      in_r_d = sync1_q;
      cnt_d  = '0;
    end else if (sync1_q == in_r_q) begin
      cnt_d = '0;
    end else if (cnt_q >= thresh_i) begin
      in_r_d = sync1_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync0_q  <= 1'b0;
      sync1_q  <= 1'b0;
      in_r_q   <= 1'b0;
      in_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync0_q  <= pad_i;
      sync1_q  <= sync0_q;
      in_r_q   <= in_r_d;
      in_dly_q <= in_r_q;
      cnt_q    <= cnt_d;
    end
  end

  assign in_o   = in_r_q;
  assign in_q_o = in_dly_q;

endmodule

// File: rtl/apb_gpio_ext.sv
// APB GPIO controller: banked pin registers, atomic output updates, filtered
// inputs, sticky W1C interrupt status, level interrupt and wake-up request.
module apb_gpio_ext
  import apb_gpio_ext_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_GPIO       = 64,
  parameter int FILT_W         = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_GPIO-1:0]       gpio_in,
  output logic [NUM_GPIO-1:0]       gpio_in_sync,
  output logic [NUM_GPIO-1:0]       gpio_out,
  output logic [NUM_GPIO-1:0]       gpio_dir,
  output logic                      power_event,
  output logic                      interrupt
);

  localparam int NUM_BANKS = NUM_GPIO / BANK_SIZE;

  logic [BANK_W-1:0] bank;
  logic [REG_W-1:0]  reg_idx;
  logic              bank_ok;
  logic              wr_en;
  logic              unused_addr;

  assign bank        = PADDR[BANK_LSB +: BANK_W];
  assign reg_idx     = PADDR[REG_LSB +: REG_W];
  assign bank_ok     = {1'b0, bank} < 3'(NUM_BANKS);
  assign wr_en       = PSEL & PENABLE & PWRITE & bank_ok;
  assign unused_addr = ^{PADDR[APB_ADDR_WIDTH-1:BANK_LSB+BANK_W], PADDR[REG_LSB-1:0]};

  logic [NUM_GPIO-1:0] dir_q, dir_d, out_q, out_d, inten_q, inten_d;
  logic [NUM_GPIO-1:0] type0_q, type0_d, type1_q, type1_d;
  logic [NUM_GPIO-1:0] status_q, status_d, filt_en_q, filt_en_d, pwrevt_q, pwrevt_d;
  logic [FILT_W-1:0]   filt_cfg_q [NUM_BANKS];
  logic [FILT_W-1:0]   filt_cfg_d [NUM_BANKS];
  logic [NUM_GPIO-1:0] w1c, evt, in_r, in_dly;
  logic                interrupt_q, power_event_q;

  always_comb begin
    dir_d      = dir_q;
    out_d      = out_q;
    inten_d    = inten_q;
    type0_d    = type0_q;
    type1_d    = type1_q;
    filt_en_d  = filt_en_q;
    pwrevt_d   = pwrevt_q;
    filt_cfg_d = filt_cfg_q;
    w1c        = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wr_en && bank == BANK_W'(b)) begin
        case (reg_idx)
          REG_DIR:       dir_d[b*BANK_SIZE +: BANK_SIZE]     = PWDATA;
          REG_OUT:       out_d[b*BANK_SIZE +: BANK_SIZE]     = PWDATA;
          REG_OUT_SET:   out_d[b*BANK_SIZE +: BANK_SIZE]     = out_q[b*BANK_SIZE +: BANK_SIZE] | PWDATA;
          REG_OUT_CLR:   out_d[b*BANK_SIZE +: BANK_SIZE]     = out_q[b*BANK_SIZE +: BANK_SIZE] & ~PWDATA;
          REG_OUT_TGL:   out_d[b*BANK_SIZE +: BANK_SIZE]     = out_q[b*BANK_SIZE +: BANK_SIZE] ^ PWDATA;
          REG_INTEN:     inten_d[b*BANK_SIZE +: BANK_SIZE]   = PWDATA;
          REG_INTTYPE0:  type0_d[b*BANK_SIZE +: BANK_SIZE]   = PWDATA;
          REG_INTTYPE1:  type1_d[b*BANK_SIZE +: BANK_SIZE]   = PWDATA;
          REG_INTSTATUS: w1c[b*BANK_SIZE +: BANK_SIZE]       = PWDATA;
          REG_FILT_EN:   filt_en_d[b*BANK_SIZE +: BANK_SIZE] = PWDATA;
          REG_FILT_CFG:  filt_cfg_d[b]                       = PWDATA[FILT_W-1:0];
          REG_PWREVT:    pwrevt_d[b*BANK_SIZE +: BANK_SIZE]  = PWDATA;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    evt = '0;
    for (int p = 0; p < NUM_GPIO; p++) begin
      evt[p] = inten_q[p] & int_match({type1_q[p], type0_q[p]}, in_r[p], in_dly[p]);
    end
  end

  // A new event in the same cycle as its W1C keeps the bit set
  assign status_d = (status_q & ~w1c) | evt;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dir_q         <= '0;
      out_q         <= '0;
      inten_q       <= '0;
      type0_q       <= '0;
      type1_q       <= '0;
      status_q      <= '0;
      filt_en_q     <= '0;
      pwrevt_q      <= '0;
      interrupt_q   <= 1'b0;
      power_event_q <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) filt_cfg_q[b] <= '0;
    end else begin
      dir_q         <= dir_d;
      out_q         <= out_d;
      inten_q       <= inten_d;
      type0_q       <= type0_d;
      type1_q       <= type1_d;
      status_q      <= status_d;
      filt_en_q     <= filt_en_d;
      pwrevt_q      <= pwrevt_d;
      filt_cfg_q    <= filt_cfg_d;
      interrupt_q   <= |(status_d & inten_q);
      power_event_q <= |(pwrevt_q & in_r);
    end
  end

  for (genvar p = 0; p < NUM_GPIO; p++) begin : g_pin
    gpio_in_filter #(.FILT_W(FILT_W)) u_filt (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .pad_i     (gpio_in[p]),
      .filt_en_i (filt_en_q[p]),
      .thresh_i  (filt_cfg_q[p / BANK_SIZE]),
      .in_o      (in_r[p]),
      .in_q_o    (in_dly[p])
    );
  end

  always_comb begin
    PRDATA = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank == BANK_W'(b)) begin
        case (reg_idx)
          REG_DIR:       PRDATA = dir_q[b*BANK_SIZE +: BANK_SIZE];
          REG_IN:        PRDATA = in_r[b*BANK_SIZE +: BANK_SIZE];
          REG_OUT:       PRDATA = out_q[b*BANK_SIZE +: BANK_SIZE];
          REG_INTEN:     PRDATA = inten_q[b*BANK_SIZE +: BANK_SIZE];
          REG_INTTYPE0:  PRDATA = type0_q[b*BANK_SIZE +: BANK_SIZE];
          REG_INTTYPE1:  PRDATA = type1_q[b*BANK_SIZE +: BANK_SIZE];
          REG_INTSTATUS: PRDATA = status_q[b*BANK_SIZE +: BANK_SIZE];
          REG_FILT_EN:   PRDATA = filt_en_q[b*BANK_SIZE +: BANK_SIZE];
          REG_FILT_CFG:  PRDATA = 32'(filt_cfg_q[b]);
          REG_PWREVT:    PRDATA = pwrevt_q[b*BANK_SIZE +: BANK_SIZE];
          default:       PRDATA = '0;
        endcase
      end
    end
  end

  assign PREADY       = 1'b1;
  assign PSLVERR      = PSEL & ~bank_ok;
  assign gpio_in_sync = in_r;
  assign gpio_out     = out_q;
  assign gpio_dir     = dir_q;
  assign interrupt    = interrupt_q;
  assign power_event  = power_event_q;

endmodule

// File: tb/tb_apb_gpio_ext.sv
// Bench for apb_gpio_ext: directed scenarios plus random APB/pad traffic,
// compared every cycle against a pin-level behavioural model.
module tb_apb_gpio_ext;

  localparam int AW = 12;
  localparam int NG = 64;
  localparam int FW = 8;
  localparam int NB = NG / 32;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic [AW-1:0] PADDR = '0;
  logic [31:0]   PWDATA = '0;
  logic          PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR;
  logic [NG-1:0] gpio_in = '0;
  logic [NG-1:0] gpio_in_sync, gpio_out, gpio_dir;
  logic          power_event, interrupt;

  apb_gpio_ext #(.APB_ADDR_WIDTH(AW), .NUM_GPIO(NG), .FILT_W(FW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .gpio_in(gpio_in), .gpio_in_sync(gpio_in_sync), .gpio_out(gpio_out), .gpio_dir(gpio_dir),
    .power_event(power_event), .interrupt(interrupt)
  );

  always #5 HCLK = ~HCLK;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
  endtask

  // Reference model
  logic [NG-1:0] m_dir = '0, m_out = '0, m_inten = '0, m_t0 = '0, m_t1 = '0;
  logic [NG-1:0] m_stat = '0, m_fen = '0, m_pwr = '0;
  logic [NG-1:0] m_in = '0, m_inq = '0, m_p1 = '0, m_p2 = '0;
  logic [FW-1:0] m_cfg [NB];
  int            m_run [NG];
  logic          m_irq = 1'b0, m_pev = 1'b0;

  function automatic void model_step();
    logic [NG-1:0] ev, w1c, nin;
    logic [31:0]   d;
    int            bi, ri, bank_of_pin;
    bit            hit, arrived;
    if (HRESET) begin
      m_dir = '0; m_out = '0; m_inten = '0; m_t0 = '0; m_t1 = '0;
      m_stat = '0; m_fen = '0; m_pwr = '0;
      m_in = '0; m_inq = '0; m_p1 = '0; m_p2 = '0;
      for (int b = 0; b < NB; b++) m_cfg[b] = '0;
      for (int p = 0; p < NG; p++) m_run[p] = 0;
      m_irq = 1'b0; m_pev = 1'b0;
      return;
    end
    bi  = int'(PADDR[7:6]);
    ri  = int'(PADDR[5:2]);
    d   = PWDATA;
    hit = PSEL && PENABLE && PWRITE && (bi < NB);
    w1c = '0;
    if (hit && ri == 9) w1c[bi*32 +: 32] = d;
    ev = '0;
    for (int p = 0; p < NG; p++) begin
      case ({m_t1[p], m_t0[p]})
        2'b00: ev[p] = m_in[p];
        2'b01: ev[p] = !m_in[p];
        2'b10: ev[p] = m_in[p] && !m_inq[p];
        default: ev[p] = !m_in[p] && m_inq[p];
      endcase
      ev[p] = ev[p] & m_inten[p];
    end
    m_irq  = |(((m_stat & ~w1c) | ev) & m_inten);
    m_pev  = |(m_pwr & m_in);
    m_stat = (m_stat & ~w1c) | ev;
    // pad value seen at the filter is the one sampled two edges ago
    nin = m_in;
    for (int p = 0; p < NG; p++) begin
      arrived = m_p2[p];
      bank_of_pin = p / 32;
      if (!m_fen[p]) begin
        nin[p] = arrived; m_run[p] = 0;
      end else if (arrived == m_in[p]) begin
        m_run[p] = 0;
      end else if (m_run[p] >= int'(m_cfg[bank_of_pin])) begin
        nin[p] = arrived; m_run[p] = 0;
      end else begin
        m_run[p] = m_run[p] + 1;
      end
    end
    m_inq = m_in;
    m_in  = nin;
    m_p2  = m_p1;
    m_p1  = gpio_in;
    if (hit) begin
      case (ri)
        0:  m_dir[bi*32 +: 32]   = d;
        2:  m_out[bi*32 +: 32]   = d;
        3:  m_out[bi*32 +: 32]   = m_out[bi*32 +: 32] | d;
        4:  m_out[bi*32 +: 32]   = m_out[bi*32 +: 32] & ~d;
        5:  m_out[bi*32 +: 32]   = m_out[bi*32 +: 32] ^ d;
        6:  m_inten[bi*32 +: 32] = d;
        7:  m_t0[bi*32 +: 32]    = d;
        8:  m_t1[bi*32 +: 32]    = d;
        10: m_fen[bi*32 +: 32]   = d;
        11: m_cfg[bi]            = d[FW-1:0];
        12: m_pwr[bi*32 +: 32]   = d;
        default: ;
      endcase
    end
  endfunction

  function automatic logic [31:0] m_read(input int b, input int r);
    if (b >= NB) return 32'h0;
    case (r)
      0:  return m_dir[b*32 +: 32];
      1:  return m_in[b*32 +: 32];
      2:  return m_out[b*32 +: 32];
      6:  return m_inten[b*32 +: 32];
      7:  return m_t0[b*32 +: 32];
      8:  return m_t1[b*32 +: 32];
      9:  return m_stat[b*32 +: 32];
      10: return m_fen[b*32 +: 32];
      11: return 32'(m_cfg[b]);
      12: return m_pwr[b*32 +: 32];
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    for (int b = 0; b < NB; b++) m_cfg[b] = '0;
    for (int p = 0; p < NG; p++) m_run[p] = 0;
  end

  always @(posedge HCLK) model_step();

  always @(negedge HCLK) begin
    if (chk_on) begin
      check_val("gpio_out", gpio_out, m_out);
      check_val("gpio_dir", gpio_dir, m_dir);
      check_val("gpio_in_sync", gpio_in_sync, m_in);
      check_val("interrupt", interrupt, m_irq);
      check_val("power_event", power_event, m_pev);
    end
  end

  task automatic apb(input bit wr, input int b, input int r, input logic [31:0] d,
                     output logic [31:0] rd);
    logic [1:0] bb;
    logic [3:0] rr;
    bb = b[1:0];
    rr = r[3:0];
    @(negedge HCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PWDATA = d;
    PADDR = '0;
    PADDR[11:8] = 4'($urandom);
    PADDR[7:6] = bb;
    PADDR[5:2] = rr;
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1;
    rd = PRDATA;
    check_val($sformatf("prdata b%0d r%0d", b, r), PRDATA, m_read(b, r));
    check_val("pslverr", PSLVERR, (b >= NB));
    check_val("pready", PREADY, 1'b1);
    @(posedge HCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input int b, input int r, input logic [31:0] d);
    logic [31:0] dummy;
    apb(1'b1, b, r, d, dummy);
  endtask

  task automatic rd(input int b, input int r, output logic [31:0] v);
    apb(1'b0, b, r, 32'h0, v);
  endtask

  initial begin
    logic [31:0] v, d;
    int b, r;
    HRESET = 1'b1;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    chk_on = 1'b1;

    // reset clears everything after being configured
    wr(0, 0, 32'hDEAD_BEEF);
    wr(1, 2, 32'h1234_5678);
    wr(0, 6, 32'hFFFF_0000);
    wr(1, 11, 32'h7);
    wr(0, 12, 32'h0000_00FF);
    @(negedge HCLK); HRESET = 1'b1;
    @(negedge HCLK); HRESET = 1'b0;
    check_val("rst_dir", gpio_dir, 64'h0);
    check_val("rst_out", gpio_out, 64'h0);
    check_val("rst_irq", interrupt, 1'b0);
    check_val("rst_pev", power_event, 1'b0);
    for (int bb = 0; bb < NB; bb++)
      for (int rr = 0; rr < 16; rr++) begin
        rd(bb, rr, v);
        check_val($sformatf("rst_reg b%0d r%0d", bb, rr), v, 32'h0);
      end

    // atomic output updates
    wr(0, 2, 32'h0000_00F0);
    wr(0, 3, 32'h0000_0001);
    wr(0, 4, 32'h0000_0010);
    wr(0, 5, 32'h0000_0300);
    @(negedge HCLK);
    check_val("out_atomic", gpio_out[31:0], 32'h0000_03E1);

    // glitch filter on pin 33
    wr(1, 10, 32'h2);
    wr(1, 11, 32'd4);
    @(negedge HCLK); gpio_in[33] = 1'b1;
    repeat (4) @(negedge HCLK);
    gpio_in[33] = 1'b0;
    repeat (10) @(negedge HCLK);
    rd(1, 1, v);
    check_val("filt_short", v, 32'h0);
    @(negedge HCLK); gpio_in[33] = 1'b1;
    repeat (6) @(negedge HCLK);
    check_val("filt_long_early", gpio_in_sync[33], 1'b0);
    gpio_in[33] = 1'b0;
    @(negedge HCLK);
    check_val("filt_long", gpio_in_sync[33], 1'b1);
    repeat (12) @(negedge HCLK);

    // rising-edge interrupt on pin 5
    wr(0, 8, 32'h20);
    wr(0, 6, 32'h20);
    @(negedge HCLK); gpio_in[5] = 1'b1;
    repeat (3) @(negedge HCLK);
    check_val("rise_irq_pre", interrupt, 1'b0);
    @(negedge HCLK);
    check_val("rise_irq", interrupt, 1'b1);
    rd(0, 9, v);
    check_val("rise_stat", v, 32'h20);
    wr(0, 9, 32'h20);
    @(negedge HCLK);
    check_val("rise_w1c_irq", interrupt, 1'b0);
    rd(0, 9, v);
    check_val("rise_w1c_stat", v, 32'h0);

    // level-high pin 0 survives W1C while held
    wr(0, 6, 32'h21);
    @(negedge HCLK); gpio_in[0] = 1'b1;
    repeat (5) @(negedge HCLK);
    wr(0, 9, 32'h1);
    rd(0, 9, v);
    check_val("lvl_w1c_stat", v[0], 1'b1);
    check_val("lvl_w1c_irq", interrupt, 1'b1);

    // W1C landing on the same edge as a new rise on pin 5
    @(negedge HCLK); gpio_in[5] = 1'b0;
    repeat (6) @(negedge HCLK);
    gpio_in[5] = 1'b1;
    @(negedge HCLK);
    wr(0, 9, 32'h20);
    rd(0, 9, v);
    check_val("w1c_vs_rise", v[5], 1'b1);
    gpio_in[0] = 1'b0;
    repeat (5) @(negedge HCLK);
    wr(0, 9, 32'h21);
    rd(0, 9, v);
    check_val("stat_cleared", v, 32'h0);

    // out-of-range bank
    wr(3, 0, 32'hFFFF_FFFF);
    wr(2, 2, 32'hFFFF_FFFF);
    rd(3, 2, v);
    check_val("bad_prdata", v, 32'h0);
    check_val("bad_dir", gpio_dir, 64'h0);

    // wake-up on pin 2
    wr(0, 12, 32'h4);
    @(negedge HCLK); gpio_in[2] = 1'b1;
    repeat (3) @(negedge HCLK);
    check_val("pev_pre", power_event, 1'b0);
    @(negedge HCLK);
    check_val("pev", power_event, 1'b1);

    // random traffic
    for (int it = 0; it < 400; it++) begin
      @(negedge HCLK);
      if ($urandom_range(0, 2) == 0)
        gpio_in = gpio_in ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      b = $urandom_range(0, 3);
      r = $urandom_range(0, 15);
      d = $urandom;
      if (r == 11) d = $urandom_range(0, 6);
      if ($urandom_range(0, 1) == 1) wr(b, r, d);
      else rd(b, r, v);
    end

    repeat (5) @(negedge HCLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
